// File: rtl/sd_cmd_pkg.sv
// Shared constants and encodings for the SD SPI-mode command sequencer.
// Command indices, R1 bytes, error causes and FSM state encodings.
package sd_cmd_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam logic [7:0] R1_IDLE  = 8'h01;
    localparam logic [7:0] R1_READY = 8'h00;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_CMD0   = 3'd1;
    localparam logic [2:0] ERR_CMD55  = 3'd2;
    localparam logic [2:0] ERR_ACMD41 = 3'd3;
    localparam logic [2:0] ERR_CMD16  = 3'd4;

    localparam logic [31:0] BLOCK_LEN = 32'd512;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_CMD0,
        ST_CMD55,
        ST_ACMD41,
        ST_CMD16,
        ST_IDLE,
        ST_CMD17,
        ST_FAIL
    } mainState_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ISSUE,
        PH_WAIT_LOW,
        PH_WAIT_HIGH
    } phase_t;

endpackage

// File: rtl/sd_card_sequencer_handshake.sv
// Issue / wait-low / wait-high handshake with the SD command executor.
// respValid marks the cycle in which the top decodes the R1 byte.
module sd_cmd_handshake
    import sd_cmd_pkg::*;
(
    input  logic clk400,
    input  logic reset,
    input  logic go,
    input  logic commandDone,
    output logic startCommand,
    output logic respValid
);

    phase_t phase;

    always_ff @(posedge clk400) begin
        if (reset) begin
            phase <= PH_IDLE;
        end else begin
            unique case (phase)
                PH_IDLE:      if (go && commandDone) phase <= PH_ISSUE;
                PH_ISSUE:     phase <= PH_WAIT_LOW;
                PH_WAIT_LOW:  if (!commandDone) phase <= PH_WAIT_HIGH;
                PH_WAIT_HIGH: if (commandDone) phase <= PH_IDLE;
                default:      phase <= PH_IDLE;
            endcase
        end
    end

    // The executor still shows done during ISSUE, so only a low-then-high counts.
    assign startCommand = (phase == PH_ISSUE);
    assign respValid    = (phase == PH_WAIT_HIGH) && commandDone;

endmodule

// File: rtl/sd_card_sequencer.sv
// SPI-mode SD init sequence (CMD0, CMD55/ACMD41, CMD16) and CMD17 reads.
// Drives the executor's command/argument/startCommand interface.
module sd_card_sequencer
    import sd_cmd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 80,
    parameter int unsigned ACMD41_RETRIES = 1000
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        readRequest,
    input  logic [22:0] blockAddress,
    output logic        ready,
    output logic        readDone,
    output logic        readError,
    output logic        initError,
    output logic [2:0]  errorCode,
    output logic        csN,
    output logic [5:0]  command,
    output logic [31:0] argument,
    output logic        startCommand,
    input  logic        commandDone,
    input  logic [7:0]  response
);

    localparam int PW = $clog2(POWERUP_CYCLES);
    localparam int RW = $clog2(ACMD41_RETRIES + 1);

    mainState_t    state;
    logic [PW-1:0] powerupCount;
    logic [RW-1:0] retryCount;
    logic          go;
    logic          respValid;

    assign go = (state == ST_CMD0) || (state == ST_CMD55) ||
                (state == ST_ACMD41) || (state == ST_CMD16) ||
                (state == ST_CMD17);

    sd_cmd_handshake handshake (
        .clk400       (clk400),
        .reset        (reset),
        .go           (go),
        .commandDone  (commandDone),
        .startCommand (startCommand),
        .respValid    (respValid)
    );

    always_ff @(posedge clk400) begin
        if (reset) begin
            state        <= ST_POWERUP;
            powerupCount <= '0;
            retryCount   <= '0;
            ready        <= 1'b0;
            readDone     <= 1'b0;
            readError    <= 1'b0;
            initError    <= 1'b0;
            errorCode    <= ERR_NONE;
            csN          <= 1'b1;
            command      <= CMD0;
            argument     <= '0;
        end else begin
            readDone  <= 1'b0;
            readError <= 1'b0;
            unique case (state)
                ST_POWERUP: begin
                    // Leave one cycle early: the handshake adds one before the start pulse.
                    if (32'(powerupCount) == POWERUP_CYCLES - 2) begin
                        state    <= ST_CMD0;
                        csN      <= 1'b0;
                        command  <= CMD0;
                        argument <= '0;
                    end else begin
                        powerupCount <= powerupCount + PW'(1);
                    end
                end
                ST_CMD0: if (respValid) begin
                    if (response == R1_IDLE) begin
                        state   <= ST_CMD55;
                        command <= CMD55;
                    end else begin
                        state     <= ST_FAIL;
                        initError <= 1'b1;
                        errorCode <= ERR_CMD0;
                    end
                end
                ST_CMD55: if (respValid) begin
                    if (response[7:1] == 7'd0) begin
                        state   <= ST_ACMD41;
                        command <= CMD41;
                    end else begin
                        state     <= ST_FAIL;
                        initError <= 1'b1;
                        errorCode <= ERR_CMD55;
                    end
                end
                ST_ACMD41: if (respValid) begin
                    if (response == R1_READY) begin
                        state    <= ST_CMD16;
                        command  <= CMD16;
                        argument <= BLOCK_LEN;
                    end else if (response == R1_IDLE &&
                                 32'(retryCount) + 32'd1 < ACMD41_RETRIES) begin
                        retryCount <= retryCount + RW'(1);
                        state      <= ST_CMD55;
                        command    <= CMD55;
                    end else begin
                        if (response == R1_IDLE)
                            retryCount <= retryCount + RW'(1);
                        state     <= ST_FAIL;
                        initError <= 1'b1;
                        errorCode <= ERR_ACMD41;
                    end
                end
                ST_CMD16: if (respValid) begin
                    if (response == R1_READY) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        state     <= ST_FAIL;
                        initError <= 1'b1;
                        errorCode <= ERR_CMD16;
                    end
                end
                ST_IDLE: if (readRequest) begin
                    state    <= ST_CMD17;
                    ready    <= 1'b0;
                    command  <= CMD17;
                    argument <= {blockAddress, 9'b0};
                end
                ST_CMD17: if (respValid) begin
                    state     <= ST_IDLE;
                    ready     <= 1'b1;
                    readDone  <= (response == R1_READY);
                    readError <= (response != R1_READY);
                end
                ST_FAIL: ;
                default: state <= ST_FAIL;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_sequencer.sv
// Directed bench for sd_card_sequencer with a behavioural executor model.
// Each scenario task drives stimulus and checks its own expectations.
module tb_sd_card_sequencer;

    logic        clk400 = 1'b0;
    logic        reset = 1'b1;
    logic        readRequest = 1'b0;
    logic [22:0] blockAddress = '0;
    logic        ready, readDone, readError, initError, csN, startCommand;
    logic [2:0]  errorCode;
    logic [5:0]  command;
    logic [31:0] argument;
    logic        commandDone = 1'b1;
    logic [7:0]  response = 8'hFF;

    int errors = 0;
    int checks = 0;

    sd_card_sequencer dut (
        .clk400       (clk400),
        .reset        (reset),
        .readRequest  (readRequest),
        .blockAddress (blockAddress),
        .ready        (ready),
        .readDone     (readDone),
        .readError    (readError),
        .initError    (initError),
        .errorCode    (errorCode),
        .csN          (csN),
        .command      (command),
        .argument     (argument),
        .startCommand (startCommand),
        .commandDone  (commandDone),
        .response     (response)
    );

    always #5 clk400 = ~clk400;

    // Executor model: config is written by tests, state only by the model.
    int         holdCycles = 0;
    int         busyCycles = 2;
    logic [7:0] respTable [16];
    int         respN = 0;
    int         respBase = 0;
    logic [7:0] defaultResp = 8'h00;

    int          exState = 0;
    int          holdLeft = 0;
    int          busyLeft = 0;
    int          protocolErr = 0;
    logic [5:0]  cmdLog [$];
    logic [31:0] argLog [$];

    always @(posedge clk400) begin
        if (reset) begin
            exState     <= 0;
            commandDone <= 1'b1;
        end else begin
            case (exState)
                0: if (startCommand) begin
                    cmdLog.push_back(command);
                    argLog.push_back(argument);
                    if (holdCycles == 0) begin
                        commandDone <= 1'b0;
                        busyLeft    <= busyCycles;
                        exState     <= 2;
                    end else begin
                        holdLeft <= holdCycles;
                        exState  <= 1;
                    end
                end
                1: begin
                    if (startCommand) protocolErr <= protocolErr + 1;
                    if (holdLeft == 1) begin
                        commandDone <= 1'b0;
                        busyLeft    <= busyCycles;
                        exState     <= 2;
                    end else begin
                        holdLeft <= holdLeft - 1;
                    end
                end
                default: begin
                    if (startCommand) protocolErr <= protocolErr + 1;
                    if (busyLeft <= 1) begin
                        commandDone <= 1'b1;
                        if (cmdLog.size() - 1 - respBase < respN)
                            response <= respTable[cmdLog.size() - 1 - respBase];
                        else
                            response <= defaultResp;
                        exState <= 0;
                    end else begin
                        busyLeft <= busyLeft - 1;
                    end
                end
            endcase
        end
    end

    int doneCount = 0;
    int errCount = 0;
    int startRun = 0;
    int maxStartLen = 0;
    int readyLagErr = 0;

    always @(negedge clk400) begin
        if (readDone) doneCount <= doneCount + 1;
        if (readError) errCount <= errCount + 1;
        if (readDone && !ready) readyLagErr <= readyLagErr + 1;
        if (startCommand) begin
            startRun <= startRun + 1;
            if (startRun + 1 > maxStartLen) maxStartLen <= startRun + 1;
        end else begin
            startRun <= 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic release_reset(output int startCycle, output bit csnEarly);
        reset = 1'b1;
        repeat (3) @(posedge clk400);
        @(negedge clk400);
        reset = 1'b0;
        startCycle = -1;
        csnEarly = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk400);
            #1;
            if (n <= 74 && csN !== 1'b1) csnEarly = 1'b1;
            if (startCommand === 1'b1) begin
                startCycle = n;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk400);
            #1;
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_init_error(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk400);
            #1;
            if (initError === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue_read(input logic [22:0] addr);
        @(negedge clk400);
        readRequest  = 1'b1;
        blockAddress = addr;
        @(negedge clk400);
        readRequest = 1'b0;
    endtask

    task automatic test_reset;
        logic [46:0] got;
        reset = 1'b1;
        repeat (2) @(posedge clk400);
        #1;
        got = {ready, readDone, readError, initError, errorCode,
               csN, startCommand, command, argument};
        checks++;
        if (got !== {7'b0, 1'b1, 1'b0, 6'b0, 32'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", got,
                     {7'b0, 1'b1, 1'b0, 6'b0, 32'b0});
        end
    endtask

    task automatic test_init_nominal;
        logic [5:0] expCmd [6] = '{6'd0, 6'd55, 6'd41, 6'd55, 6'd41, 6'd16};
        int  sc, base;
        bit  early, ok;
        holdCycles = 0;
        busyCycles = 2;
        respTable[0:4] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
        respN = 5;
        respBase = cmdLog.size();
        base = cmdLog.size();
        release_reset(sc, early);
        checks++;
        if (sc !== 80) begin
            errors++;
            $display("FAIL first_start_cycle: got %0d expected 80", sc);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL powerup_csN: got csN low within 74 cycles expected high");
        end
        checks++;
        if (csN !== 1'b0 || command !== 6'd0) begin
            errors++;
            $display("FAIL cmd0_issue: got csN=%b cmd=%0d expected csN=0 cmd=0", csN, command);
        end
        wait_ready(500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL init_ready: got ready=%b expected 1", ready);
        end
        checks++;
        if (cmdLog.size() - base != 6) begin
            errors++;
            $display("FAIL init_cmd_count: got %0d expected 6", cmdLog.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (cmdLog[base + i] !== expCmd[i]) begin
                    errors++;
                    $display("FAIL init_cmd_%0d: got %0d expected %0d",
                             i, cmdLog[base + i], expCmd[i]);
                end
            end
            checks++;
            if (argLog[base + 5] !== 32'd512 || argLog[base] !== 32'd0) begin
                errors++;
                $display("FAIL init_args: got cmd16 %0d cmd0 %0d expected 512 0",
                         argLog[base + 5], argLog[base]);
            end
        end
        checks++;
        if (initError !== 1'b0) begin
            errors++;
            $display("FAIL init_no_error: got %b expected 0", initError);
        end
    endtask

    task automatic test_read;
        int base, d0, e0, l0;
        bit ok;
        respTable[0] = 8'h00;
        respN = 1;
        respBase = cmdLog.size();
        busyCycles = 10;
        base = cmdLog.size();
        d0 = doneCount;
        e0 = errCount;
        l0 = readyLagErr;
        issue_read(23'h000003);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL read_ready_drop: got %b expected 0", ready);
        end
        // A request while busy must be ignored.
        repeat (3) @(negedge clk400);
        readRequest  = 1'b1;
        blockAddress = 23'h000005;
        @(negedge clk400);
        readRequest = 1'b0;
        wait_ready(200, ok);
        repeat (10) @(negedge clk400);
        checks++;
        if (!ok || ready !== 1'b1) begin
            errors++;
            $display("FAIL read_ready_back: got %b expected 1", ready);
        end
        checks++;
        if (cmdLog.size() - base != 1) begin
            errors++;
            $display("FAIL read_cmd_count: got %0d expected 1", cmdLog.size() - base);
        end else begin
            checks++;
            if (cmdLog[base] !== 6'd17 || argLog[base] !== 32'h00000600) begin
                errors++;
                $display("FAIL read_cmd: got cmd %0d arg %h expected 17 00000600",
                         cmdLog[base], argLog[base]);
            end
        end
        checks++;
        if (doneCount - d0 != 1 || errCount - e0 != 0) begin
            errors++;
            $display("FAIL read_pulses: got done %0d err %0d expected 1 0",
                     doneCount - d0, errCount - e0);
        end
        checks++;
        if (readyLagErr - l0 != 0) begin
            errors++;
            $display("FAIL read_ready_with_done: got %0d lagging pulses expected 0",
                     readyLagErr - l0);
        end
    endtask

    task automatic test_read_error;
        int d0, e0;
        bit ok;
        respTable[0] = 8'h04;
        respN = 1;
        respBase = cmdLog.size();
        d0 = doneCount;
        e0 = errCount;
        issue_read(23'h000010);
        wait_ready(200, ok);
        repeat (5) @(negedge clk400);
        checks++;
        if (!ok || ready !== 1'b1) begin
            errors++;
            $display("FAIL rderr_ready: got %b expected 1", ready);
        end
        checks++;
        if (errCount - e0 != 1 || doneCount - d0 != 0) begin
            errors++;
            $display("FAIL rderr_pulses: got err %0d done %0d expected 1 0",
                     errCount - e0, doneCount - d0);
        end
        checks++;
        if (initError !== 1'b0 || errorCode !== 3'd0) begin
            errors++;
            $display("FAIL rderr_init: got %b code %0d expected 0 0", initError, errorCode);
        end
    endtask

    task automatic test_back_to_back;
        int base, d0;
        bit ok1, ok2;
        respTable[0:1] = '{8'h00, 8'h00};
        respN = 2;
        respBase = cmdLog.size();
        base = cmdLog.size();
        d0 = doneCount;
        issue_read(23'h7FFFFF);
        wait_ready(200, ok1);
        issue_read(23'h000000);
        wait_ready(200, ok2);
        repeat (3) @(negedge clk400);
        checks++;
        if (!ok1 || !ok2 || cmdLog.size() - base != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d reads expected 2", cmdLog.size() - base);
        end else begin
            checks++;
            if (argLog[base] !== 32'hFFFFFE00 || argLog[base + 1] !== 32'h0) begin
                errors++;
                $display("FAIL b2b_args: got %h %h expected FFFFFE00 00000000",
                         argLog[base], argLog[base + 1]);
            end
        end
        checks++;
        if (doneCount - d0 != 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d expected 2", doneCount - d0);
        end
    endtask

    task automatic test_handshake;
        int sc, base, p0;
        bit early, ok;
        holdCycles = 3;
        busyCycles = 20;
        respTable[0:4] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
        respN = 5;
        p0 = protocolErr;
        respBase = cmdLog.size();
        base = cmdLog.size();
        release_reset(sc, early);
        wait_ready(2000, ok);
        checks++;
        if (!ok || cmdLog.size() - base != 6) begin
            errors++;
            $display("FAIL hs_init: got ready=%b cmds %0d expected 1 6",
                     ready, cmdLog.size() - base);
        end
        checks++;
        if (protocolErr - p0 != 0) begin
            errors++;
            $display("FAIL hs_early_eval: got %0d starts while busy expected 0",
                     protocolErr - p0);
        end
        checks++;
        if (maxStartLen != 1) begin
            errors++;
            $display("FAIL hs_start_len: got %0d expected 1", maxStartLen);
        end
        holdCycles = 0;
        busyCycles = 2;
    endtask

    task automatic test_cmd0_fault;
        int sc, base;
        bit early, ok;
        respTable[0] = 8'h00;
        respN = 1;
        respBase = cmdLog.size();
        base = cmdLog.size();
        release_reset(sc, early);
        wait_init_error(200, ok);
        repeat (50) @(negedge clk400);
        checks++;
        if (!ok || errorCode !== 3'd1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL cmd0_fault: got err=%b code %0d ready %b expected 1 1 0",
                     initError, errorCode, ready);
        end
        checks++;
        if (cmdLog.size() - base != 1) begin
            errors++;
            $display("FAIL cmd0_fault_quiet: got %0d cmds expected 1", cmdLog.size() - base);
        end
    endtask

    task automatic test_acmd41_timeout;
        int sc, base, n41, n55;
        bit early, ok;
        respN = 0;
        defaultResp = 8'h01;
        busyCycles = 1;
        respBase = cmdLog.size();
        base = cmdLog.size();
        release_reset(sc, early);
        wait_init_error(20000, ok);
        repeat (10) @(negedge clk400);
        n41 = 0;
        n55 = 0;
        for (int i = base; i < cmdLog.size(); i++) begin
            if (cmdLog[i] == 6'd41) n41++;
            if (cmdLog[i] == 6'd55) n55++;
        end
        checks++;
        if (!ok || errorCode !== 3'd3) begin
            errors++;
            $display("FAIL acmd41_code: got err=%b code %0d expected 1 3", initError, errorCode);
        end
        checks++;
        if (n41 != 1000 || n55 != 1000 || cmdLog[cmdLog.size() - 1] !== 6'd41) begin
            errors++;
            $display("FAIL acmd41_count: got acmd41 %0d cmd55 %0d expected 1000 1000",
                     n41, n55);
        end
    endtask

    task automatic test_reset_mid;
        logic [46:0] got;
        int  sc;
        bit  early, found;
        respN = 0;
        defaultResp = 8'h01;
        busyCycles = 20;
        respBase = cmdLog.size();
        release_reset(sc, early);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk400);
            #1;
            if (command === 6'd41 && commandDone === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        repeat (5) @(posedge clk400);
        @(negedge clk400);
        reset = 1'b1;
        @(posedge clk400);
        #1;
        got = {ready, readDone, readError, initError, errorCode,
               csN, startCommand, command, argument};
        checks++;
        if (!found || got !== {7'b0, 1'b1, 1'b0, 6'b0, 32'b0}) begin
            errors++;
            $display("FAIL midreset_values: got %h expected %h", got,
                     {7'b0, 1'b1, 1'b0, 6'b0, 32'b0});
        end
        busyCycles = 2;
        release_reset(sc, early);
        checks++;
        if (sc !== 80 || early || command !== 6'd0) begin
            errors++;
            $display("FAIL midreset_restart: got start %0d cmd %0d expected 80 0",
                     sc, command);
        end
    endtask

    initial begin
        test_reset();
        test_init_nominal();
        test_read();
        test_read_error();
        test_back_to_back();
        test_handshake();
        test_cmd0_fault();
        test_acmd41_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
